// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path: FSM states and oversampling points.
package uart_pkg;

  typedef enum logic [2:0] {
    RECOVER = 3'd0,
    IDLE    = 3'd1,
    START   = 3'd2,
    DATA    = 3'd3,
    PARITY  = 3'd4,
    STOP    = 3'd5
  } state_t;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned SAMPLE_LO  = 7;
  localparam int unsigned SAMPLE_MID = 8;
  localparam int unsigned SAMPLE_HI  = 9;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial pin in, received byte and status strobes out.
interface uart_rx_if;
  logic       RxD;
  logic [7:0] RxD_data;
  logic       RxD_data_ready;
  logic       framing_error;
  logic       parity_error;
  logic       busy;

  modport master (
    input  RxD,
    output RxD_data, RxD_data_ready, framing_error, parity_error, busy
  );

  modport slave (
    output RxD,
    input  RxD_data, RxD_data_ready, framing_error, parity_error, busy
  );
endinterface

// File: rtl/uart_baud_tick.sv
// Free-running divider: registered one-cycle tick every DIV clocks.
module uart_baud_tick #(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == CW'(DIV - 1));
      if (cnt == CW'(DIV - 1)) cnt <= '0;
      else                     cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/uart_rx.sv
// 16x oversampled UART receiver, 8N1 by default; define UART_RX_PARITY_EN for 8E1 framing.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 32_000_000,
  parameter int unsigned BAUD     = 1_000_000
) (
  input  logic      clk,
  input  logic      rst,
  uart_rx_if.master bus
);
  localparam int unsigned DIV = CLK_FREQ / (BAUD * OVERSAMPLE);

  if (DIV < 2 || (CLK_FREQ % (BAUD * OVERSAMPLE)) != 0) begin : g_bad_cfg
    $error("uart_rx: CLK_FREQ/(BAUD*16) must be an integer >= 2");
  end

  logic [1:0] sync;
  logic       rx_s;
  logic       tick;
  state_t     state;
  logic [3:0] os_cnt;
  logic [2:0] bit_idx;
  logic [7:0] shreg;
  logic       smp_lo;
  logic       smp_mid;
  logic       vote_c;

  // Pin synchronizer held at idle level through reset
  always_ff @(posedge clk) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], bus.RxD};
  end
  assign rx_s = sync[1];

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign vote_c = maj3(smp_lo, smp_mid, rx_s);

`ifdef UART_RX_PARITY_EN
  logic par_err;
`else
  assign bus.parity_error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= RECOVER;
      os_cnt             <= '0;
      bit_idx            <= '0;
      shreg              <= '0;
      smp_lo             <= 1'b0;
      smp_mid            <= 1'b0;
      bus.RxD_data       <= '0;
      bus.RxD_data_ready <= 1'b0;
      bus.framing_error  <= 1'b0;
      bus.busy           <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err            <= 1'b0;
      bus.parity_error   <= 1'b0;
`endif
    end else begin
      bus.RxD_data_ready <= 1'b0;
      bus.framing_error  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      bus.parity_error   <= 1'b0;
`endif
      if (tick) begin
        case (state)
          // Wait for an idle-high line so a stuck-low pin is never taken as a start bit
          RECOVER: if (rx_s) state <= IDLE;
          IDLE: begin
            if (!rx_s) begin
              state    <= START;
              os_cnt   <= '0;
              bus.busy <= 1'b1;
            end
          end
          default: begin
            os_cnt <= os_cnt + 4'd1;
            if (os_cnt == 4'(SAMPLE_LO))  smp_lo  <= rx_s;
            if (os_cnt == 4'(SAMPLE_MID)) smp_mid <= rx_s;
            if (os_cnt == 4'(SAMPLE_HI)) begin
              case (state)
                START: begin
                  if (vote_c) begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                  end else begin
                    state   <= DATA;
                    bit_idx <= '0;
                  end
                end
                DATA: begin
                  shreg   <= {vote_c, shreg[7:1]};
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                    state <= PARITY;
`else
                    state <= STOP;
`endif
                  end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                  par_err <= (^shreg) != vote_c;
                  state   <= STOP;
                end
`endif
                STOP: begin
                  bus.busy <= 1'b0;
                  if (vote_c) begin
                    bus.RxD_data       <= shreg;
                    bus.RxD_data_ready <= 1'b1;
`ifdef UART_RX_PARITY_EN
                    bus.parity_error   <= par_err;
`endif
                    state              <= IDLE;
                  end else begin
                    bus.framing_error <= 1'b1;
                    state             <= RECOVER;
                  end
                end
                default: begin
                  state    <= RECOVER;
                  bus.busy <= 1'b0;
                end
              endcase
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// Randomized bench for uart_rx: drives serial frames and compares delivered bytes against a frame-level model.
module tb_uart_rx;
  localparam int unsigned BIT_CLK = 32;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  uart_rx_if bus();

  uart_rx #(.CLK_FREQ(32_000_000), .BAUD(1_000_000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int fe_cnt   = 0;
  int wide_cnt = 0;
  int ready_cyc = 0;
  int start_cyc = 0;
  int chk_idx  = 0;
  logic prev_ready = 1'b0;
  logic [7:0] got_q[$];
  logic       got_pe[$];
  logic [7:0] exp_q[$];
  logic       exp_pe[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Record every strobe seen on the output side
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_ready = 1'b0;
      end else begin
        cyc++;
        if (bus.RxD_data_ready) begin
          got_q.push_back(bus.RxD_data);
          got_pe.push_back(bus.parity_error);
          ready_cyc = cyc;
        end
        if (bus.framing_error) fe_cnt++;
        if (bus.RxD_data_ready && prev_ready) wide_cnt++;
        prev_ready = bus.RxD_data_ready;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.RxD = 1'b1;
    end
  endtask

  // One frame: start, 8 data LSB-first, optional parity, stop; optional 1-clk glitch inside data bits
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_v,
                            input int glitch_off, input logic chk_busy);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (PAR_EN) bits.push_back(par_v);
    bits.push_back(stop);
    for (int b = 0; b < bits.size(); b++) begin
      for (int k = 0; k < int'(BIT_CLK); k++) begin
        @(negedge clk);
        if (b == 0 && k == 0) start_cyc = cyc;
        if (glitch_off >= 0 && b >= 1 && b <= 8 && k == glitch_off) bus.RxD = ~bits[b];
        else                                                     bus.RxD = bits[b];
        if (chk_busy && b == 5 && k == 0) check("busy_mid_frame", 32'(bus.busy), 32'd1);
      end
    end
    if (stop) begin
      exp_q.push_back(d);
      exp_pe.push_back(PAR_EN && ((^d) != par_v));
    end
  endtask

  task automatic check_rx(input string tag);
    int n;
    check({tag, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = chk_idx; i < n; i++) begin
      check({tag, "_data"}, 32'(got_q[i]), 32'(exp_q[i]));
      check({tag, "_perr"}, 32'(got_pe[i]), 32'(exp_pe[i]));
    end
    chk_idx = n;
  endtask

  initial begin
    int lat;
    int fe_before;
    int got_before;
    logic [7:0] d;
    int gap;
    int g;
    logic pv;

    bus.RxD = 1'b1;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_data",  32'(bus.RxD_data), 32'h0);
    check("rst_ready", 32'(bus.RxD_data_ready), 32'h0);
    check("rst_ferr",  32'(bus.framing_error), 32'h0);
    check("rst_perr",  32'(bus.parity_error), 32'h0);
    check("rst_busy",  32'(bus.busy), 32'h0);
    rst = 1'b0;
    idle(40);

    // Single frame, latency from start edge to strobe
    send_frame(8'h55, 1'b1, ^8'h55, -1, 1'b1);
    lat = ready_cyc - start_cyc;
    check("latency_in_window",
          32'(lat >= 290 + (PAR_EN ? 32 : 0) && lat <= 330 + (PAR_EN ? 32 : 0)), 32'd1);
    idle(20);
    check_rx("t1");
    check("t1_busy_after", 32'(bus.busy), 32'd0);
    check("t1_data_reg", 32'(bus.RxD_data), 32'h55);

    // Short low glitch is rejected as a start bit
    repeat (8) begin
      @(negedge clk);
      bus.RxD = 1'b0;
    end
    idle(80);
    check("glitch_no_strobe", got_q.size(), exp_q.size());
    check("glitch_busy", 32'(bus.busy), 32'd0);
    check("glitch_no_ferr", fe_cnt, 0);
    send_frame(8'h3C, 1'b1, ^8'h3C, -1, 1'b0);
    idle(20);
    check_rx("t2");

    // Bad stop bit: framing error, data register untouched
    send_frame(8'hA3, 1'b0, ^8'hA3, -1, 1'b0);
    idle(60);
    check("ferr_count", fe_cnt, 1);
    check("ferr_no_ready", got_q.size(), exp_q.size());
    check("ferr_data_kept", 32'(bus.RxD_data), 32'h3C);
    send_frame(8'h11, 1'b1, ^8'h11, -1, 1'b0);
    idle(20);
    check_rx("t3");

    // Back-to-back frames with no idle gap
    send_frame(8'h00, 1'b1, ^8'h00, -1, 1'b0);
    send_frame(8'hFF, 1'b1, ^8'hFF, -1, 1'b0);
    idle(20);
    check_rx("t4");

    // One-clock inversion near the sampling window of every data bit
    send_frame(8'h0F, 1'b1, ^8'h0F, 22, 1'b0);
    idle(20);
    check_rx("t5");
    check("t5_data_reg", 32'(bus.RxD_data), 32'h0F);

    // Random bytes, gaps, glitches and parity bits
    for (int i = 0; i < 24; i++) begin
      d   = 8'($urandom);
      gap = int'($urandom_range(0, 40));
      g   = ($urandom_range(0, 1) != 0) ? int'($urandom_range(18, 26)) : -1;
      pv  = 1'($urandom_range(0, 1));
      send_frame(d, 1'b1, pv, g, 1'b0);
      idle(gap);
    end
    idle(20);
    check_rx("rand");

    // Reset in the middle of a frame, line held low afterwards
    repeat (3 * BIT_CLK) begin
      @(negedge clk);
      bus.RxD = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_data_cleared", 32'(bus.RxD_data), 32'h0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    fe_before  = fe_cnt;
    got_before = got_q.size();
    repeat (200) begin
      @(negedge clk);
      bus.RxD = 1'b0;
    end
    check("stuck_low_no_strobe", got_q.size(), got_before);
    check("stuck_low_no_ferr", fe_cnt, fe_before);
    check("stuck_low_busy", 32'(bus.busy), 32'd0);
    idle(60);
    send_frame(8'h96, 1'b1, ^8'h96, -1, 1'b0);
    idle(20);
    check_rx("t7");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h01, 1'b1, 1'b0, -1, 1'b0);
    send_frame(8'h03, 1'b1, 1'b0, -1, 1'b0);
    idle(20);
    check_rx("parity");
`endif

    check("ready_one_cycle", wide_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
